// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core front end.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  typedef struct packed {
    bus32_t pc;
    bus32_t instr;
  } fetch_entry_t;

  localparam bus32_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; storage cleared on reset.
module fetch_fifo import tartaruga_pkg::*; #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    push_data_i,
  input  logic            pop_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t    head_o
);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  fetch_entry_t    r_mem [Depth];

  // Flush wins over push/pop in the same cycle; pointers wrap naturally (Depth is 2^n).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (pop_i) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (push_i && !pop_i) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (pop_i && !push_i) begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  assign count_o = r_cnt;
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// buffering and redirect with drop counting of stale in-flight responses.
module fetch_unit import tartaruga_pkg::*; #(
  parameter bus32_t      RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   redirect_valid_i,
  input  bus32_t redirect_pc_i,
  output logic   imem_req_valid_o,
  input  logic   imem_req_ready_i,
  output bus32_t imem_req_addr_o,
  input  logic   imem_rsp_valid_i,
  input  bus32_t imem_rsp_data_i,
  output logic   instr_valid_o,
  input  logic   instr_ready_i,
  output bus32_t instr_o,
  output bus32_t pc_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  bus32_t          r_fetch_pc;
  bus32_t          r_rsp_pc;
  logic [CntW-1:0] r_inflight;
  logic [CntW-1:0] r_drop_cnt;

  logic [CntW-1:0] w_fifo_cnt;
  logic [CntW:0]   w_credit_sum;
  logic            w_credit_ok;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_rsp_dec;
  bus32_t          w_redirect_pc;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  // Buffered plus outstanding never exceeds the FIFO depth, so a push always has room.
  assign w_credit_sum  = {1'b0, w_fifo_cnt} + {1'b0, r_inflight};
  assign w_credit_ok   = w_credit_sum < (CntW + 1)'(FIFO_DEPTH);
  assign w_redirect_pc = redirect_pc_i & ~32'h3;

  assign imem_req_valid_o = !rst_i && !redirect_valid_i && w_credit_ok;
  assign imem_req_addr_o  = r_fetch_pc;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

  assign w_push = imem_rsp_valid_i && !redirect_valid_i && (r_drop_cnt == '0);
  assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data_i};

  assign instr_valid_o = !rst_i && !redirect_valid_i && (w_fifo_cnt != '0);
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;

  assign w_rsp_dec = imem_rsp_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid_i) begin
      // A response landing in the redirect cycle is itself stale and already retired here.
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
      r_inflight <= r_inflight - CntW'(w_rsp_dec);
      r_drop_cnt <= r_inflight - CntW'(w_rsp_dec);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_inflight <= r_inflight + CntW'(w_req_fire) - CntW'(w_rsp_dec);
      if (imem_rsp_valid_i) begin
        if (r_drop_cnt != '0) begin
          r_drop_cnt <= r_drop_cnt - CntW'(1);
        end else begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_valid_i),
    .push_i     (w_push),
    .push_data_i(w_push_data),
    .pop_i      (w_pop),
    .count_o    (w_fifo_cnt),
    .head_o     (w_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable in-order memory model.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o (imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] fire_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_instr_q[$];
  int          pop_cyc_q[$];
  logic        wait_pend = 1'b0;
  logic [31:0] wait_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    fire_q.delete();
    pop_pc_q.delete();
    pop_instr_q.delete();
    pop_cyc_q.delete();
  endtask

  // Observe the current cycle, clock it, then present any due memory response.
  task automatic tick();
    #1;
    if (rst_i) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      wait_pend = 1'b0;
    end else begin
      if (wait_pend && !redirect_valid_i) check_eq("addr_stable", imem_req_addr_o, wait_addr);
      wait_pend = imem_req_valid_o && !imem_req_ready_i;
      wait_addr = imem_req_addr_o;
      if (imem_req_valid_o && imem_req_ready_i) begin
        mem_addr_q.push_back(imem_req_addr_o);
        mem_due_q.push_back(cyc + lat);
        fire_q.push_back(imem_req_addr_o);
      end
      if (instr_valid_o && instr_ready_i) begin
        pop_pc_q.push_back(pc_o);
        pop_instr_q.push_back(instr_o);
        pop_cyc_q.push_back(cyc);
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_addr_q[0] >> 2;
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b1;
    instr_ready_i    = 1'b0;
    tick();
    check_eq("rst_req_valid", imem_req_valid_o, 1'b0);
    check_eq("rst_instr_valid", instr_valid_o, 1'b0);
    tick();
    check_eq("rst_addr", imem_req_addr_o, 32'h0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", pc_o, 32'h0);
    rst_i = 1'b0;
    cyc   = 0;
    clear_logs();
  endtask

  initial begin
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    instr_ready_i    = 1'b0;

    // Streaming, 1-cycle memory, decode always ready.
    lat = 1;
    do_reset();
    instr_ready_i = 1'b1;
    #1;
    check_eq("first_req_valid", imem_req_valid_o, 1'b1);
    check_eq("first_req_addr", imem_req_addr_o, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("stream_pops", (pop_pc_q.size() >= 6), 1'b1);
    for (int i = 0; i < 6 && i < pop_pc_q.size(); i++) begin
      check_eq("stream_pc", pop_pc_q[i], 32'(i * 4));
      check_eq("stream_instr", pop_instr_q[i], 32'(i));
      check_eq("stream_cyc", pop_cyc_q[i], 32'(i + 2));
    end

    // Decode held off: exactly four requests, then resume at 0x10.
    lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    #1;
    check_eq("bp_fires", fire_q.size(), 32'd4);
    check_eq("bp_req_valid", imem_req_valid_o, 1'b0);
    check_eq("bp_instr_valid", instr_valid_o, 1'b1);
    check_eq("bp_head_pc", pc_o, 32'h0);
    instr_ready_i = 1'b1;
    tick();
    #1;
    check_eq("bp_resume_valid", imem_req_valid_o, 1'b1);
    check_eq("bp_resume_addr", imem_req_addr_o, 32'h10);
    for (int i = 0; i < 6; i++) tick();
    check_eq("bp_pops", (pop_pc_q.size() >= 5), 1'b1);
    for (int i = 0; i < 5 && i < pop_pc_q.size(); i++) begin
      check_eq("bp_pc", pop_pc_q[i], 32'(i * 4));
    end

    // 3-cycle memory with ready toggling every cycle.
    lat = 3;
    do_reset();
    instr_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready_i = ~imem_req_ready_i;
      tick();
    end
    imem_req_ready_i = 1'b1;
    check_eq("slow_pops", (pop_pc_q.size() >= 8), 1'b1);
    for (int i = 0; i < pop_pc_q.size(); i++) begin
      check_eq("slow_pc", pop_pc_q[i], 32'(i * 4));
      check_eq("slow_instr", pop_instr_q[i], 32'(i));
    end

    // Redirect with two requests in flight and two entries buffered
    // (the credit rule caps buffered plus in-flight at four).
    lat = 3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      imem_req_ready_i = (cyc != 2);
      tick();
    end
    imem_req_ready_i = 1'b1;
    check_eq("redir_fires", fire_q.size(), 32'd4);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_1003;
    #1;
    check_eq("redir_req_masked", imem_req_valid_o, 1'b0);
    check_eq("redir_instr_masked", instr_valid_o, 1'b0);
    tick();
    redirect_valid_i = 1'b0;
    instr_ready_i    = 1'b1;
    #1;
    check_eq("redir_next_valid", imem_req_valid_o, 1'b1);
    check_eq("redir_next_addr", imem_req_addr_o, 32'h0000_1000);
    for (int i = 0; i < 8; i++) tick();
    check_eq("redir_pops", (pop_pc_q.size() >= 2), 1'b1);
    if (pop_pc_q.size() >= 2) begin
      check_eq("redir_pc0", pop_pc_q[0], 32'h0000_1000);
      check_eq("redir_instr0", pop_instr_q[0], 32'h0000_0400);
      check_eq("redir_pc1", pop_pc_q[1], 32'h0000_1004);
    end

    // Redirect coinciding with a response and a would-be pop.
    lat = 1;
    do_reset();
    instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0200;
    #1;
    check_eq("same_instr_valid", instr_valid_o, 1'b0);
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check_eq("same_empty", instr_valid_o, 1'b0);
    check_eq("same_next_addr", imem_req_addr_o, 32'h0000_0200);
    for (int i = 0; i < 4; i++) tick();
    check_eq("same_pops", (pop_pc_q.size() >= 2), 1'b1);
    if (pop_pc_q.size() >= 2) begin
      check_eq("same_pc0", pop_pc_q[0], 32'h0);
      check_eq("same_cyc0", pop_cyc_q[0], 32'd2);
      check_eq("same_pc1", pop_pc_q[1], 32'h0000_0200);
      check_eq("same_instr1", pop_instr_q[1], 32'h0000_0080);
      check_eq("same_cyc1", pop_cyc_q[1], 32'd6);
    end

    // Address wrap at the top of memory, then reset mid-stream.
    lat = 1;
    do_reset();
    instr_ready_i    = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFE;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    check_eq("wrap_addr0", imem_req_addr_o, 32'hFFFF_FFFC);
    tick();
    #1;
    check_eq("wrap_addr1", imem_req_addr_o, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("wrap_pops", (pop_pc_q.size() >= 2), 1'b1);
    if (pop_pc_q.size() >= 2) begin
      check_eq("wrap_pc0", pop_pc_q[0], 32'hFFFF_FFFC);
      check_eq("wrap_instr0", pop_instr_q[0], 32'h3FFF_FFFF);
      check_eq("wrap_pc1", pop_pc_q[1], 32'h0);
    end
    rst_i = 1'b1;
    #1;
    check_eq("midrst_req_valid", imem_req_valid_o, 1'b0);
    check_eq("midrst_instr_valid", instr_valid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    clear_logs();
    #1;
    check_eq("postrst_instr_valid", instr_valid_o, 1'b0);
    check_eq("postrst_req_valid", imem_req_valid_o, 1'b1);
    check_eq("postrst_addr", imem_req_addr_o, 32'h0);
    check_eq("postrst_instr", instr_o, 32'h0);
    check_eq("postrst_pc", pc_o, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("postrst_pops", (pop_pc_q.size() >= 1), 1'b1);
    if (pop_pc_q.size() >= 1) check_eq("postrst_pc0", pop_pc_q[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
